// File: rtl/ram256_bist_pkg.sv
// ram256_bist_pkg: FSM states, element type and March C- element table for ram256_bist
package ram256_bist_pkg;
  localparam int ADDR_W = 8;
  localparam int NUM_ELEM = 6;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RW, S_RDONLY, S_CHK, S_DONE} state_t;
  typedef logic [2:0] elem_t;
  typedef struct packed {
    logic down;
    logic rd;
    logic rd_bg;
    logic wr;
    logic wr_bg;
  } march_t;
  function automatic march_t march(input elem_t e);
    case (e)
      3'd0: return march_t'(5'b0_0_0_1_0);
      3'd1: return march_t'(5'b0_1_0_1_1);
      3'd2: return march_t'(5'b0_1_1_1_0);
      3'd3: return march_t'(5'b1_1_0_1_1);
      3'd4: return march_t'(5'b1_1_1_1_0);
      3'd5: return march_t'(5'b0_1_0_0_0);
      default: return march_t'(5'b0);
    endcase
  endfunction
endpackage

// File: rtl/ram256_bist.sv
// ram256_bist: March C- self-test controller driving a RAM256 port, reports pass and first failure
// Ports: CLK/RST (async high), start in; busy/done/pass and fail_addr/fail_elem/fail_data out;
//        EN0/WE0/A0/Di0 out and Do0 in form the RAM256 initiator port.
module ram256_bist
  import ram256_bist_pkg::*;
#(
  parameter int WSIZE = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W-1:0]   fail_addr,
  output logic [2:0]          fail_elem,
  output logic [WSIZE*8-1:0]  fail_data,
  output logic                EN0,
  output logic [WSIZE-1:0]    WE0,
  output logic [ADDR_W-1:0]   A0,
  output logic [WSIZE*8-1:0]  Di0,
  input  logic [WSIZE*8-1:0]  Do0
);
  localparam int DW = WSIZE * 8;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_cnt, w_addr;
  elem_t r_elem;
  march_t w_cur;
  logic w_last, w_cmp, w_fail, w_wr;
  logic [DW-1:0] w_diff;
  assign w_cur = march(r_elem);
  // the counter always runs upward; descending elements see it inverted
  assign w_addr = w_cur.down ? ~r_cnt : r_cnt;
  assign w_last = &r_cnt;
  // the first RDONLY cycle has no read data yet; CHK consumes the last one
  assign w_cmp = w_cur.rd && (r_state == S_RW || (r_state == S_RDONLY && r_cnt != '0) || r_state == S_CHK);
  assign w_diff = Do0 ^ {DW{w_cur.rd_bg}};
  assign w_fail = w_cmp && |w_diff;
  assign w_wr = (r_state == S_WR || r_state == S_RW) && w_cur.wr;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = start ? S_WR : S_IDLE;
      S_WR:     w_next = w_last ? S_RD : S_WR;
      S_RD:     w_next = S_RW;
      S_RW:     w_next = w_fail ? S_DONE : (w_last && r_elem == elem_t'(NUM_ELEM - 2)) ? S_RDONLY : S_RD;
      S_RDONLY: w_next = w_fail ? S_DONE : w_last ? S_CHK : S_RDONLY;
      S_CHK:    w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end
  always_comb begin
    EN0 = r_state inside {S_WR, S_RD, S_RW, S_RDONLY};
    busy = r_state != S_IDLE && r_state != S_DONE;
    done = r_state == S_DONE;
    WE0 = w_wr ? '1 : '0;
    A0 = EN0 ? w_addr : '0;
    Di0 = (w_wr && w_cur.wr_bg) ? '1 : '0;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
      r_elem <= '0;
      pass <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_cnt <= '0;
        r_elem <= '0;
        pass <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
        fail_data <= '0;
      end
      if (r_state inside {S_WR, S_RW, S_RDONLY}) r_cnt <= r_cnt + 1'b1;
      if ((r_state == S_WR || r_state == S_RW) && w_last) r_elem <= r_elem + 1'b1;
      // in RDONLY/CHK the data belongs to the previous (ascending) address
      if (w_fail) begin
        fail_addr <= r_state == S_RW ? w_addr : r_cnt - 1'b1;
        fail_elem <= r_elem;
        fail_data <= w_diff;
      end
      if (r_state == S_CHK && !w_fail) pass <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ram256_bist.sv
// tb_ram256_bist: directed scenarios for ram256_bist against a RAM256 model with injectable stuck-at bits
module tb_ram256_bist;
  localparam int WSIZE = 4;
  localparam int DW = WSIZE * 8;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic start = 1'b0;
  logic busy, done, pass, EN0;
  logic [7:0] fail_addr, A0;
  logic [2:0] fail_elem;
  logic [DW-1:0] fail_data, Di0;
  logic [DW-1:0] Do0 = '0;
  logic [WSIZE-1:0] WE0;
  logic [DW-1:0] mem [256];
  logic [7:0] sa1_addr = '0, sa0_addr = '0;
  logic [DW-1:0] sa1_mask = '0, sa0_mask = '0;
  int n_cmp = 0, n_err = 0;
  always #5 CLK = ~CLK;
  ram256_bist #(.WSIZE(WSIZE)) dut (
    .CLK(CLK), .RST(RST), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data),
    .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(Do0)
  );
  always @(posedge CLK) begin
    if (EN0) begin
      if (WE0 != '0) begin
        for (int b = 0; b < WSIZE; b++) if (WE0[b]) mem[A0][b*8+:8] <= Di0[b*8+:8];
      end else begin
        Do0 <= (mem[A0] | (A0 == sa1_addr ? sa1_mask : '0)) & ~(A0 == sa0_addr ? sa0_mask : '0);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic run(input bit hold, output int cyc, output int bcnt);
    start = 1'b1;
    @(posedge CLK); #1;
    start = hold;
    cyc = 0;
    bcnt = 0;
    while (!done && cyc < 3000) begin
      bcnt += int'(busy);
      @(posedge CLK); #1;
      cyc++;
    end
  endtask
  task automatic test_reset();
    RST = 1'b0;
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, pass, EN0} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: busy/done/pass/EN0 got %b required 0000", {busy, done, pass, EN0});
    end
    n_cmp++;
    if ({fail_addr, fail_elem, fail_data} !== '0) begin
      n_err++;
      $display("FAIL reset_fail_regs: got %h/%h/%h required 0/0/0", fail_addr, fail_elem, fail_data);
    end
    n_cmp++;
    if ({WE0, A0, Di0} !== '0) begin
      n_err++;
      $display("FAIL reset_ram_bus: WE0=%h A0=%h Di0=%h required 0", WE0, A0, Di0);
    end
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    n_cmp++;
    if ({busy, EN0} !== 2'b0) begin
      n_err++;
      $display("FAIL idle_quiet: busy/EN0 got %b required 00", {busy, EN0});
    end
  endtask
  task automatic test_pass();
    int cyc, bc, nz;
    run(1'b0, cyc, bc);
    n_cmp++;
    if (cyc !== 2561) begin n_err++; $display("FAIL pass_done_cycle: got %0d required 2561", cyc); end
    n_cmp++;
    if (bc !== 2561) begin n_err++; $display("FAIL pass_busy_len: got %0d required 2561", bc); end
    n_cmp++;
    if ({pass, busy} !== 2'b10) begin n_err++; $display("FAIL pass_flag: pass/busy got %b required 10", {pass, busy}); end
    n_cmp++;
    if ({fail_addr, fail_elem, fail_data} !== '0) begin
      n_err++;
      $display("FAIL pass_fail_regs: got %h/%h/%h required 0/0/0", fail_addr, fail_elem, fail_data);
    end
    nz = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== '0) nz++;
    n_cmp++;
    if (nz !== 0) begin n_err++; $display("FAIL pass_final_ram: %0d nonzero words required 0", nz); end
    @(posedge CLK); #1;
    n_cmp++;
    if ({done, busy, pass} !== 3'b001) begin
      n_err++;
      $display("FAIL pass_after_done: done/busy/pass got %b required 001", {done, busy, pass});
    end
  endtask
  task automatic test_access_pattern();
    int t_cyc [13] = '{0, 255, 256, 257, 769, 1280, 1281, 1283, 1791, 1793, 2304, 2559, 2560};
    logic [44:0] t_exp [13] = '{
      {1'b1, 4'hF, 8'h00, 32'h0}, {1'b1, 4'hF, 8'hFF, 32'h0}, {1'b1, 4'h0, 8'h00, 32'h0},
      {1'b1, 4'hF, 8'h00, 32'hFFFFFFFF}, {1'b1, 4'hF, 8'h00, 32'h0}, {1'b1, 4'h0, 8'hFF, 32'h0},
      {1'b1, 4'hF, 8'hFF, 32'hFFFFFFFF}, {1'b1, 4'hF, 8'hFE, 32'hFFFFFFFF}, {1'b1, 4'hF, 8'h00, 32'hFFFFFFFF},
      {1'b1, 4'hF, 8'hFF, 32'h0}, {1'b1, 4'h0, 8'h00, 32'h0}, {1'b1, 4'h0, 8'hFF, 32'h0},
      {1'b0, 4'h0, 8'h00, 32'h0}};
    logic [7:0] ea;
    logic [3:0] ew;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int c = 0; c < 2562; c++) begin
      if (c > 0) begin @(posedge CLK); #1; end
      for (int k = 0; k < 13; k++) begin
        if (c == t_cyc[k]) begin
          n_cmp++;
          if ({EN0, WE0, A0, Di0} !== t_exp[k]) begin
            n_err++;
            $display("FAIL access_c%0d: EN0/WE0/A0/Di0 got %b/%h/%h/%h required %h", c, EN0, WE0, A0, Di0, t_exp[k]);
          end
        end
      end
      if (c >= 1280 && c < 1792) begin
        ea = 8'(255 - (c - 1280) / 2);
        ew = ((c - 1280) % 2 == 1) ? 4'hF : 4'h0;
        n_cmp++;
        if ({A0, WE0} !== {ea, ew}) begin
          n_err++;
          $display("FAIL e3_order_c%0d: A0/WE0 got %h/%h required %h/%h", c, A0, WE0, ea, ew);
        end
      end
    end
    n_cmp++;
    if ({done, pass} !== 2'b11) begin n_err++; $display("FAIL access_done: done/pass got %b required 11", {done, pass}); end
    @(posedge CLK); #1;
  endtask
  task automatic test_stuck_at_1();
    int cyc, bc;
    sa1_addr = 8'h5A;
    sa1_mask = 32'h0000_0008;
    run(1'b0, cyc, bc);
    n_cmp++;
    if (cyc !== 438) begin n_err++; $display("FAIL sa1_done_cycle: got %0d required 438", cyc); end
    n_cmp++;
    if (pass !== 1'b0) begin n_err++; $display("FAIL sa1_pass: got %b required 0", pass); end
    n_cmp++;
    if ({fail_addr, fail_elem, fail_data} !== {8'h5A, 3'd1, 32'h0000_0008}) begin
      n_err++;
      $display("FAIL sa1_report: got %h/%h/%h required 5a/1/00000008", fail_addr, fail_elem, fail_data);
    end
    sa1_mask = '0;
    @(posedge CLK); #1;
  endtask
  task automatic test_stuck_at_0();
    int cyc, bc;
    sa0_addr = 8'h00;
    sa0_mask = 32'h8000_0000;
    run(1'b0, cyc, bc);
    n_cmp++;
    if (cyc !== 770) begin n_err++; $display("FAIL sa0_done_cycle: got %0d required 770", cyc); end
    n_cmp++;
    if (pass !== 1'b0) begin n_err++; $display("FAIL sa0_pass: got %b required 0", pass); end
    n_cmp++;
    if ({fail_addr, fail_elem, fail_data} !== {8'h00, 3'd2, 32'h8000_0000}) begin
      n_err++;
      $display("FAIL sa0_report: got %h/%h/%h required 00/2/80000000", fail_addr, fail_elem, fail_data);
    end
    sa0_mask = '0;
    @(posedge CLK); #1;
  endtask
  task automatic test_abort();
    int cyc, bc;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (1000) begin @(posedge CLK); #1; end
    n_cmp++;
    if ({busy, EN0} !== 2'b11) begin n_err++; $display("FAIL abort_pre: busy/EN0 got %b required 11", {busy, EN0}); end
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, pass, EN0, WE0, A0, Di0} !== '0) begin
      n_err++;
      $display("FAIL abort_outputs: busy/done/pass/EN0=%b WE0=%h A0=%h Di0=%h required 0", {busy, done, pass, EN0}, WE0, A0, Di0);
    end
    n_cmp++;
    if ({fail_addr, fail_elem, fail_data} !== '0) begin
      n_err++;
      $display("FAIL abort_fail_regs: got %h/%h/%h required 0", fail_addr, fail_elem, fail_data);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    run(1'b0, cyc, bc);
    n_cmp++;
    if ({cyc, bc} !== {32'd2561, 32'd2561}) begin n_err++; $display("FAIL abort_rerun_len: done %0d busy %0d required 2561/2561", cyc, bc); end
    n_cmp++;
    if (pass !== 1'b1) begin n_err++; $display("FAIL abort_rerun_pass: got %b required 1", pass); end
    @(posedge CLK); #1;
  endtask
  task automatic test_back_to_back();
    int cyc, bc, c;
    run(1'b1, cyc, bc);
    n_cmp++;
    if ({cyc, bc} !== {32'd2561, 32'd2561}) begin n_err++; $display("FAIL b2b_first_len: done %0d busy %0d required 2561/2561", cyc, bc); end
    n_cmp++;
    if (pass !== 1'b1) begin n_err++; $display("FAIL b2b_first_pass: got %b required 1", pass); end
    @(posedge CLK); #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL b2b_idle_gap: busy/done got %b required 00", {busy, done}); end
    @(posedge CLK); #1;
    n_cmp++;
    if ({busy, pass} !== 2'b10) begin n_err++; $display("FAIL b2b_restart: busy/pass got %b required 10", {busy, pass}); end
    start = 1'b0;
    c = 0;
    while (!done && c < 3000) begin
      start = (c >= 10 && c < 13);
      @(posedge CLK); #1;
      c++;
    end
    start = 1'b0;
    n_cmp++;
    if (c !== 2561) begin n_err++; $display("FAIL b2b_second_len: got %0d required 2561", c); end
    n_cmp++;
    if (pass !== 1'b1) begin n_err++; $display("FAIL b2b_second_pass: got %b required 1", pass); end
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_no_extra_run: busy got %b required 0", busy); end
  endtask
  initial begin
    test_reset();
    test_pass();
    test_access_pattern();
    test_stuck_at_1();
    test_stuck_at_0();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
